// File: rtl/regwr_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
package regwr_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] XZR_ADDR = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_t;

  function automatic logic is_xzr(input logic [ADDR_W-1:0] addr);
    return (addr == XZR_ADDR);
  endfunction

endpackage

// File: rtl/regwr_slot.sv
// One-entry holding slot for a write requester: FULL flag, age bit, XZR drop.
module regwr_slot
  import regwr_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    active,
  input  logic    in_valid,
  input  wr_req_t in_req,
  input  logic    granted,
  input  logic    other_load,
  output logic    ready,
  output logic    load,
  output logic    full,
  output logic    older,
  output wr_req_t req
);

  logic    full_r;
  logic    older_r;
  wr_req_t req_r;
  logic    full_next_s;
  logic    older_next_s;
  logic    ready_s;
  logic    load_s;

  assign ready_s = active & (~full_r | granted);
  assign load_s  = in_valid & ready_s & ~is_xzr(in_req.addr);

  assign ready = ready_s;
  assign load  = load_s;
  assign full  = full_r;
  assign older = older_r;
  assign req   = req_r;

  // Next slot state; a fresh load is never older than the other slot.
  always_comb begin
    full_next_s  = full_r;
    older_next_s = older_r;
    if (load_s) begin
      full_next_s  = 1'b1;
      older_next_s = 1'b0;
    end else if (granted) begin
      full_next_s  = 1'b0;
      older_next_s = 1'b0;
    end else if (full_r && other_load) begin
      older_next_s = 1'b1;
    end else begin
      older_next_s = older_r;
    end
  end

  // Slot registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_r  <= 1'b0;
      older_r <= 1'b0;
      req_r   <= '0;
    end else begin
      full_r  <= full_next_s;
      older_r <= older_next_s;
      if (load_s) begin
        req_r <= in_req;
      end else begin
        req_r <= req_r;
      end
    end
  end

endmodule

// File: rtl/regwr_arbiter.sv
// Two-requester round-robin arbiter for the register-file write port.
// Optional REGWR_STATS_EN adds a saturating conflict_cnt output.
module regwr_arbiter
  import regwr_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data
`ifdef REGWR_STATS_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);

  logic              active_r;
  logic              rr_is_b_r;
  logic              rr_next_s;
  logic              wr_en_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  grant_t            gnt_s;

  wr_req_t a_in_s, b_in_s, a_req_s, b_req_s;
  logic    a_load_s, b_load_s, a_full_s, b_full_s, a_older_s, b_older_s;
  logic    a_gnt_s, b_gnt_s;

  assign a_in_s  = '{addr: a_addr, data: a_data};
  assign b_in_s  = '{addr: b_addr, data: b_data};
  assign a_gnt_s = (gnt_s == GNT_A);
  assign b_gnt_s = (gnt_s == GNT_B);

  regwr_slot u_slot_a (
    .clk        (clk),
    .reset      (reset),
    .active     (active_r),
    .in_valid   (a_valid),
    .in_req     (a_in_s),
    .granted    (a_gnt_s),
    .other_load (b_load_s),
    .ready      (a_ready),
    .load       (a_load_s),
    .full       (a_full_s),
    .older      (a_older_s),
    .req        (a_req_s)
  );

  regwr_slot u_slot_b (
    .clk        (clk),
    .reset      (reset),
    .active     (active_r),
    .in_valid   (b_valid),
    .in_req     (b_in_s),
    .granted    (b_gnt_s),
    .other_load (a_load_s),
    .ready      (b_ready),
    .load       (b_load_s),
    .full       (b_full_s),
    .older      (b_older_s),
    .req        (b_req_s)
  );

  // Grant selection: same-register writes go oldest-first (A on a tie),
  // otherwise the round-robin pointer decides and then flips.
  always_comb begin
    gnt_s     = GNT_NONE;
    rr_next_s = rr_is_b_r;
    case ({a_full_s, b_full_s})
      2'b10: gnt_s = GNT_A;
      2'b01: gnt_s = GNT_B;
      2'b11: begin
        if (a_req_s.addr == b_req_s.addr) begin
          if (b_older_s && !a_older_s) begin
            gnt_s = GNT_B;
          end else begin
            gnt_s = GNT_A;
          end
        end else begin
          if (rr_is_b_r) begin
            gnt_s = GNT_B;
          end else begin
            gnt_s = GNT_A;
          end
          rr_next_s = ~rr_is_b_r;
        end
      end
      default: gnt_s = GNT_NONE;
    endcase
  end

  // Output registers, rr pointer, and the post-reset enable for ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_r  <= 1'b0;
      rr_is_b_r <= 1'b0;
      wr_en_r   <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
    end else begin
      active_r  <= 1'b1;
      rr_is_b_r <= rr_next_s;
      case (gnt_s)
        GNT_A: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= a_req_s.addr;
          wr_data_r <= a_req_s.data;
        end
        GNT_B: begin
          wr_en_r   <= 1'b1;
          wr_addr_r <= b_req_s.addr;
          wr_data_r <= b_req_s.data;
        end
        default: wr_en_r <= 1'b0;
      endcase
    end
  end

  assign wr_en   = wr_en_r;
  assign wr_addr = wr_addr_r;
  assign wr_data = wr_data_r;

`ifdef REGWR_STATS_EN
  logic [15:0] conflict_cnt_r;

  // Saturating count of cycles with both slots occupied.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      conflict_cnt_r <= 16'd0;
    end else if (a_full_s && b_full_s && (conflict_cnt_r != 16'hFFFF)) begin
      conflict_cnt_r <= conflict_cnt_r + 16'd1;
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

  assign conflict_cnt = conflict_cnt_r;
`endif

endmodule

// File: doc/regwr_arbiter.md
# regwr_arbiter

Two-requester arbiter for the single register-file write port. It sits between the writeback stage (requester A) and the multi-cycle unit (requester B, multiply/long-latency load) and drives the write-enable, address and data that feed the 5-to-32 write decoder. Each requester has a one-entry holding slot. Grants alternate round-robin, except that same-register writes always commit in order of acceptance. Writes to XZR (X31) are accepted and discarded.

## Interface
- DATA_W, 64, register data width
- ADDR_W, 5, register address width (32 registers)
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- a_valid  in  1  requester A has a write
- a_ready  out  1  A slot can accept this cycle
- a_addr  in  ADDR_W  A destination register
- a_data  in  DATA_W  A write data
- b_valid, b_ready, b_addr, b_data: same as A, for requester B
- wr_en  out  1  register-file write enable (decoder enable)
- wr_addr  out  ADDR_W  register-file write address
- wr_data  out  DATA_W  register-file write data
- conflict_cnt  out  16  only when REGWR_STATS_EN is defined

## Operation
- Handshake: a transfer occurs on a rising edge when valid && ready. Once valid is raised, the requester holds it and its payload until the transfer.
- Slot state per requester: EMPTY or FULL, plus an age bit. The age bit marks the slot as older when it was loaded on an earlier edge than the other FULL slot.
- ready = slot EMPTY, or slot FULL and granted this cycle. This allows one transfer per cycle per requester.
- XZR drop: an accepted transfer with addr == 31 does not load the slot, so the slot stays EMPTY. It never produces wr_en.
- Arbitration runs combinationally on the slot state each cycle:
  - Only one slot FULL: grant it.
  - Both FULL with the same addr: grant the older slot.
  - Both FULL with the same addr and loaded on the same edge: grant A.
  - Both FULL with different addr: grant the rr pointer's slot. The pointer then moves to the other requester.
  - The pointer changes only on a contended grant. Its reset value is A.
- The granted slot is copied into the output registers on the next edge and becomes EMPTY. If nothing is granted, wr_en is 0 on the next edge. wr_addr and wr_data keep their last values.
- Simultaneous events:
  - A slot can be granted and reloaded by its requester on the same edge; the new entry is younger than the other FULL slot.
  - A and B can both be accepted on the same edge.
- Reset, including mid-operation:
  - Slots go EMPTY and pending writes are discarded.
  - wr_en=0, wr_addr=0, wr_data=0, pointer=A.
  - a_ready=b_ready=0 while reset is high, 1 from the first edge after release.

## Timing
- Uncontended latency: accepted at edge k, slot FULL after k; output registers loaded at edge k+1. wr_en is high for exactly the cycle following edge k+1 (2-cycle latency).
- Contended: the loser waits exactly one extra cycle.
- Throughput: the port commits one write per cycle when either slot is FULL.
- Outputs are registered; there is no combinational path from inputs to wr_*.
- ready depends combinationally on slot state and grant only, never on valid.

## Configuration
- REGWR_STATS_EN defined:
  - Adds conflict_cnt, a 16-bit counter that increments on every cycle where both slots are FULL.
  - It saturates at 0xFFFF and resets to 0.
- REGWR_STATS_EN not defined: no port, no counter. Arbitration behaviour is identical either way.

## Structure
- Package regwr_pkg holds:
  - DATA_W, ADDR_W, XZR_ADDR = 5'd31
  - wr_req_t struct {addr, data}
  - grant enum {GNT_NONE, GNT_A, GNT_B}
- Sub-module regwr_slot: the one-entry holding register with FULL flag, age bit and XZR drop, instantiated once for A and once for B. The arbiter and output registers live in regwr_arbiter.

## Test plan
- Reset then A writes X3=0x1111: wr_en high with wr_addr=3, wr_data=0x1111 exactly 2 cycles after the transfer. a_ready stays 1.
- A and B accepted on the same edge, X4=0xA and X5=0xB: X4 is committed first (pointer=A), X5 the next cycle. The pointer then favours B on the next contention.
- A and B accepted on the same edge, both X7, then another pair, both X7: the A entry commits first, then the B entry, for both pairs. After the sequence, X7 holds the value of the second pair's B entry.
- Each requester sends a write with addr=31, 0xDEAD: the handshake completes and wr_en is never asserted.
- A back-to-back writes X1..X8 with B idle: wr_en is high for 8 consecutive cycles with addresses 1..8 and a_ready never drops.
- Both slots FULL, reset pulsed mid-cycle: wr_en=0, wr_addr=0, wr_data=0 immediately. No pending write appears after release. With REGWR_STATS_EN defined, conflict_cnt=0.
